// File: rtl/lcompressor_mc_if.sv
// Sample/config/output bundle for lcompressor_mc.
// i_ce and o_ce are valid-only strobes with no ready: the block accepts one sample per i_ce cycle and pulses o_ce once per surviving sample.
interface lcompressor_mc_if #(
    parameter int W_TOTAL = 16,
    parameter int W_FRAC  = 15,
    parameter int CH_W    = 1
);
    logic                i_ce;
    logic [CH_W-1:0]     i_ch;
    logic [W_TOTAL-1:0]  i_data;
    logic                i_bypass;
    logic                i_cfg_we;
    logic [W_FRAC-1:0]   i_threshold;
    logic [W_FRAC-1:0]   i_rdiff;
    logic [W_FRAC:0]     i_attack;
    logic [W_FRAC:0]     i_release;
    logic [W_TOTAL-1:0]  o_data;
    logic [CH_W-1:0]     o_ch;
    logic                o_ce;

    modport master (
        output i_ce, i_ch, i_data, i_bypass, i_cfg_we,
        output i_threshold, i_rdiff, i_attack, i_release,
        input  o_data, o_ch, o_ce
    );

    modport slave (
        input  i_ce, i_ch, i_data, i_bypass, i_cfg_we,
        input  i_threshold, i_rdiff, i_attack, i_release,
        output o_data, o_ch, o_ce
    );
endinterface

// File: rtl/lcompressor_mc.sv
// Multi-channel linear compressor: 5-register pipeline (S1 magnitude, S2 envelope, S3 gain, S4 multiply, output).
// Define LCOMP_LINK_EN to drive every channel's gain from the loudest envelope (linked stereo).
module lcompressor_mc #(
    parameter int                W_TOTAL       = 16,
    parameter int                W_FRAC        = 15,
    parameter int                N_CH          = 2,
    parameter logic [W_TOTAL-1:0] THRESHOLD_RST = 16'h4000,
    parameter logic [W_TOTAL-1:0] RDIFF_RST     = 16'h6000,
    parameter logic [W_FRAC+1:0]  ATTACK_RST    = 17'h01000,
    parameter logic [W_FRAC+1:0]  RELEASE_RST   = 17'h00050
) (
    input  logic               i_clk,
    input  logic               i_reset,
    lcompressor_mc_if.slave    bus
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PW   = W_TOTAL + W_FRAC + 3;
    localparam logic [W_FRAC-1:0]     ENV_MAX = '1;
    localparam logic [W_FRAC:0]       UNITY   = {1'b1, {W_FRAC{1'b0}}};
    localparam logic signed [PW-1:0]  Y_MAX   = PW'(2**(W_TOTAL-1) - 1);
    localparam logic signed [PW-1:0]  Y_MIN   = PW'(-(2**(W_TOTAL-1)));

    function automatic logic [W_FRAC:0] clamp_coef(input logic [W_FRAC+1:0] c);
        return (c > {1'b0, UNITY}) ? UNITY : (W_FRAC+1)'(c);
    endfunction

    // Config shadow registers, read live by every stage.
    logic [W_FRAC-1:0] thr, rdiff;
    logic [W_FRAC:0]   coef_att, coef_rel;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            thr      <= W_FRAC'(THRESHOLD_RST);
            rdiff    <= W_FRAC'(RDIFF_RST);
            coef_att <= clamp_coef(ATTACK_RST);
            coef_rel <= clamp_coef(RELEASE_RST);
        end else if (bus.i_cfg_we) begin
            thr      <= bus.i_threshold;
            rdiff    <= bus.i_rdiff;
            coef_att <= clamp_coef({1'b0, bus.i_attack});
            coef_rel <= clamp_coef({1'b0, bus.i_release});
        end
    end

    logic ch_ok;
    generate
        if ((1 << CH_W) == N_CH) begin : g_ch_full
            assign ch_ok = 1'b1;
        end else begin : g_ch_cmp
            assign ch_ok = (32'(bus.i_ch) < 32'(N_CH));
        end
    endgenerate

    // S1: saturating magnitude.
    logic [W_TOTAL-1:0] abs_in;
    logic [W_FRAC-1:0]  mag_in;

    always_comb begin
        abs_in = bus.i_data[W_TOTAL-1] ? -bus.i_data : bus.i_data;
        mag_in = abs_in[W_TOTAL-1] ? ENV_MAX : abs_in[W_FRAC-1:0];
    end

    logic                      s1_valid, s1_bypass;
    logic [CH_W-1:0]           s1_ch;
    logic signed [W_TOTAL-1:0] s1_x;
    logic [W_FRAC-1:0]         s1_mag;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_valid  <= 1'b0;
            s1_bypass <= 1'b0;
            s1_ch     <= '0;
            s1_x      <= '0;
            s1_mag    <= '0;
        end else begin
            s1_valid <= bus.i_ce & ch_ok;
            if (bus.i_ce) begin
                s1_bypass <= bus.i_bypass;
                s1_ch     <= bus.i_ch;
                s1_x      <= bus.i_data;
                s1_mag    <= mag_in;
            end
        end
    end

    // S2: envelope follower, written back the same cycle so back-to-back samples chain.
    logic [W_FRAC-1:0]         env [N_CH];
    logic [W_FRAC-1:0]         env_cur, env_next, det_next;
    logic [W_FRAC:0]           coef;
    logic signed [W_TOTAL:0]   env_d;
    logic signed [W_FRAC+1:0]  coef_s;
    logic signed [PW-1:0]      env_upd, env_sum;

    always_comb begin
        env_cur = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (s1_ch == CH_W'(i)) env_cur = env[i];
        end
        coef    = (s1_mag > env_cur) ? coef_att : coef_rel;
        env_d   = $signed({2'b00, s1_mag}) - $signed({2'b00, env_cur});
        coef_s  = $signed({1'b0, coef});
        env_upd = PW'(env_d) * PW'(coef_s);
        env_sum = PW'($signed({1'b0, env_cur})) + (env_upd >>> W_FRAC);
        if (env_sum < 0)
            env_next = '0;
        else if (env_sum > PW'($signed({1'b0, ENV_MAX})))
            env_next = ENV_MAX;
        else
            env_next = W_FRAC'(env_sum);
        det_next = env_next;
`ifdef LCOMP_LINK_EN
        for (int i = 0; i < N_CH; i++) begin
            if (s1_ch != CH_W'(i) && env[i] > det_next) det_next = env[i];
        end
`endif
    end

    logic                      s2_valid, s2_bypass;
    logic [CH_W-1:0]           s2_ch;
    logic signed [W_TOTAL-1:0] s2_x;
    logic [W_FRAC-1:0]         s2_det;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < N_CH; i++) env[i] <= '0;
            s2_valid  <= 1'b0;
            s2_bypass <= 1'b0;
            s2_ch     <= '0;
            s2_x      <= '0;
            s2_det    <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (s1_ch == CH_W'(i)) env[i] <= env_next;
                end
                s2_bypass <= s1_bypass;
                s2_ch     <= s1_ch;
                s2_x      <= s1_x;
                s2_det    <= det_next;
            end
        end
    end

    // S3: gain = 1 - (det - thr) * rdiff above threshold.
    logic [W_FRAC-1:0]   over;
    logic [2*W_FRAC-1:0] depth_p;
    logic [W_FRAC:0]     depth, gain;

    always_comb begin
        over    = s2_det - thr;
        depth_p = (2*W_FRAC)'(over) * (2*W_FRAC)'(rdiff);
        depth   = (W_FRAC+1)'(depth_p >> W_FRAC);
        if (s2_det <= thr)
            gain = UNITY;
        else if (depth >= UNITY)
            gain = '0;
        else
            gain = UNITY - depth;
    end

    logic                      s3_valid, s3_bypass;
    logic [CH_W-1:0]           s3_ch;
    logic signed [W_TOTAL-1:0] s3_x;
    logic [W_FRAC:0]           s3_gain;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s3_valid  <= 1'b0;
            s3_bypass <= 1'b0;
            s3_ch     <= '0;
            s3_x      <= '0;
            s3_gain   <= '0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_bypass <= s2_bypass;
                s3_ch     <= s2_ch;
                s3_x      <= s2_x;
                s3_gain   <= gain;
            end
        end
    end

    // S4: full-precision product; shift and saturation happen in the output stage.
    logic                      s4_valid, s4_bypass;
    logic [CH_W-1:0]           s4_ch;
    logic signed [W_TOTAL-1:0] s4_x;
    logic signed [PW-1:0]      s4_prod;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s4_valid  <= 1'b0;
            s4_bypass <= 1'b0;
            s4_ch     <= '0;
            s4_x      <= '0;
            s4_prod   <= '0;
        end else begin
            s4_valid <= s3_valid;
            if (s3_valid) begin
                s4_bypass <= s3_bypass;
                s4_ch     <= s3_ch;
                s4_x      <= s3_x;
                s4_prod   <= PW'(s3_x) * PW'($signed({1'b0, s3_gain}));
            end
        end
    end

    logic signed [PW-1:0]      y_full;
    logic signed [W_TOTAL-1:0] y_sat;

    always_comb begin
        y_full = s4_prod >>> W_FRAC;
        if (y_full > Y_MAX)
            y_sat = W_TOTAL'(Y_MAX);
        else if (y_full < Y_MIN)
            y_sat = W_TOTAL'(Y_MIN);
        else
            y_sat = W_TOTAL'(y_full);
    end

    logic [W_TOTAL-1:0] out_data;
    logic [CH_W-1:0]    out_ch;
    logic               out_ce;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            out_data <= '0;
            out_ch   <= '0;
            out_ce   <= 1'b0;
        end else begin
            out_ce <= s4_valid;
            if (s4_valid) begin
                out_data <= s4_bypass ? s4_x : y_sat;
                out_ch   <= s4_ch;
            end
        end
    end

    assign bus.o_data = out_data;
    assign bus.o_ch   = out_ch;
    assign bus.o_ce   = out_ce;
endmodule

// File: tb/tb_lcompressor_mc.sv
// Bench for lcompressor_mc: arithmetic reference model, timed scoreboard, directed and random stimulus.
module tb_lcompressor_mc;
    localparam int W    = 16;
    localparam int WF   = 15;
    localparam int N_CH = 3;
    localparam int CH_W = 2;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    lcompressor_mc_if #(.W_TOTAL(W), .W_FRAC(WF), .CH_W(CH_W)) bus ();

    lcompressor_mc #(.W_TOTAL(W), .W_FRAC(WF), .N_CH(N_CH)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: expected data, channel and the cycle it must appear on
    logic [W-1:0]    exp_q[$];
    logic [CH_W-1:0] exp_ch_q[$];
    int              exp_due_q[$];
    logic [W-1:0]    last_data = '0;
    logic [CH_W-1:0] last_ch = '0;

    // Reference model state
    int env_m[N_CH];
    int thr_m, rdiff_m, att_m, rel_m;
    int n_thr, n_rdiff, n_att, n_rel;
    int m_env;
    logic [W-1:0] m_y;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clamp_coef(input int c);
        return (c > 32768) ? 32768 : c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) env_m[i] = 0;
        thr_m = 'h4000; rdiff_m = 'h6000; att_m = 'h1000; rel_m = 'h50;
        n_thr = thr_m; n_rdiff = rdiff_m; n_att = att_m; n_rel = rel_m;
        exp_q.delete(); exp_ch_q.delete(); exp_due_q.delete();
        last_data = '0; last_ch = '0;
    endtask

    task automatic model_sample(input int ch, input logic [W-1:0] xin, input bit byp);
        int xs, mag, e, coef, d, det, gain, depth;
        longint y;
        xs = int'($signed(xin));
        mag = (xs < 0) ? -xs : xs;
        if (mag > 32767) mag = 32767;
        e = env_m[ch];
        coef = (mag > e) ? att_m : rel_m;
        d = mag - e;
        e = e + int'((longint'(d) * coef) >>> 15);
        if (e < 0) e = 0;
        if (e > 32767) e = 32767;
        env_m[ch] = e;
        m_env = e;
        det = e;
`ifdef LCOMP_LINK_EN
        for (int i = 0; i < N_CH; i++) begin
            if (env_m[i] > det) det = env_m[i];
        end
`endif
        if (det <= thr_m) begin
            gain = 32768;
        end else begin
            depth = ((det - thr_m) * rdiff_m) >>> 15;
            gain = 32768 - depth;
            if (gain < 0) gain = 0;
        end
        y = (longint'(xs) * gain) >>> 15;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        if (byp) y = xs;
        m_y = W'(y);
    endtask

    // Driver tasks: inputs change on the falling edge
    task automatic tick(input bit ce, input int ch, input logic [W-1:0] x, input bit byp, input bit we);
        @(negedge clk);
        bus.i_ce        = ce;
        bus.i_ch        = CH_W'(ch);
        bus.i_data      = x;
        bus.i_bypass    = byp;
        bus.i_cfg_we    = we;
        bus.i_threshold = WF'(n_thr);
        bus.i_rdiff     = WF'(n_rdiff);
        bus.i_attack    = 16'(n_att);
        bus.i_release   = 16'(n_rel);
        if (we) begin
            thr_m = n_thr; rdiff_m = n_rdiff;
            att_m = clamp_coef(n_att); rel_m = clamp_coef(n_rel);
        end
        if (ce && ch < N_CH) begin
            model_sample(ch, x, byp);
            exp_q.push_back(m_y);
            exp_ch_q.push_back(CH_W'(ch));
            exp_due_q.push_back(cyc + 5);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 0, '0, 1'b0, 1'b0);
    endtask

    task automatic send(input int ch, input logic [W-1:0] x, input bit byp);
        tick(1'b1, ch, x, byp, 1'b0);
    endtask

    task automatic set_cfg(input int thr, input int rdiff, input int att, input int rel);
        n_thr = thr; n_rdiff = rdiff; n_att = att; n_rel = rel;
        tick(1'b0, 0, '0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.i_ce = 1'b0;
        bus.i_cfg_we = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Compare process: every cycle, just after the rising edge
    always begin
        @(posedge clk);
        #1;
        if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
            logic [W-1:0]    e_d;
            logic [CH_W-1:0] e_c;
            e_d = exp_q.pop_front();
            e_c = exp_ch_q.pop_front();
            void'(exp_due_q.pop_front());
            check("o_ce_valid", bus.o_ce, 1);
            check("o_data", bus.o_data, e_d);
            check("o_ch", bus.o_ch, e_c);
            last_data = e_d;
            last_ch = e_c;
        end else begin
            check("o_ce_idle", bus.o_ce, 0);
            check("o_data_hold", bus.o_data, last_data);
            check("o_ch_hold", bus.o_ch, last_ch);
        end
    end

    initial begin
        int prev;
        bus.i_ce = 1'b0; bus.i_ch = '0; bus.i_data = '0; bus.i_bypass = 1'b0;
        bus.i_cfg_we = 1'b0; bus.i_threshold = '0; bus.i_rdiff = '0;
        bus.i_attack = '0; bus.i_release = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_o_data", bus.o_data, 0);
        check("reset_o_ce", bus.o_ce, 0);

        // Below threshold: unity gain, back-to-back
        for (int i = 0; i < 8; i++) begin
            send(0, 16'h2000, 1'b0);
            check("below_thr_model", m_y, 16'h2000);
        end
        idle(6);

        // Instant attack
        set_cfg('h4000, 'h6000, 'h8000, 'h50);
        for (int i = 0; i < 4; i++) begin
            send(0, 16'h7FFF, 1'b0);
            check("attack_model_y", m_y, 16'h5000);
            check("attack_model_env", m_env, 'h7FFF);
        end
        send(0, 16'h8000, 1'b0);
        check("negfs_model", m_y, 16'hAFFF);
        send(0, 16'h8000, 1'b1);
        check("bypass_model", m_y, 16'h8000);

        // Channel isolation
        for (int i = 0; i < 6; i++) begin
            send(0, 16'h7FFF, 1'b0);
            send(1, 16'h1000, 1'b0);
`ifdef LCOMP_LINK_EN
            check("ch1_linked_model", m_y, 16'h0A00);
`else
            check("ch1_iso_model", m_y, 16'h1000);
`endif
        end
        idle(6);

        // Release decay on ch0
        send(0, 16'h7FFF, 1'b0);
        prev = m_env;
        for (int i = 0; i < 400; i++) begin
            send(0, 16'h0100, 1'b0);
            check("env_decay_model", (m_env < prev) && (m_env >= 0), 1);
            prev = m_env;
        end
        check("gain_restored_model", m_y, 16'h0100);

        // Reset with samples in flight
        idle(2);
        for (int i = 0; i < 4; i++) send(0, 16'h7FFF, 1'b0);
        do_reset();
        idle(8);
        send(0, 16'h7FFF, 1'b0);
        check("post_reset_env_model", m_env, 'hFFF);
        check("post_reset_y_model", m_y, 16'h7FFF);
        idle(6);

        // Out-of-range channel interleaved with valid ones
        send(3, 16'h1234, 1'b0);
        send(0, 16'h1000, 1'b0);
        send(3, 16'h7FFF, 1'b0);
        send(1, 16'h2000, 1'b0);
        send(2, 16'hC000, 1'b0);
        idle(6);

        // Config together with a sample: the sample sees the new config
        n_thr = 'h7FFF; n_rdiff = 'h6000; n_att = 'h8000; n_rel = 'h50;
        tick(1'b1, 0, 16'h7FFF, 1'b0, 1'b1);
        check("thr_max_model", m_y, 16'h7FFF);
        idle(6);

        // Random configurations and traffic
        for (int r = 0; r < 6; r++) begin
            idle(6);
            set_cfg($urandom_range(0, 'h7FFF), $urandom_range(0, 'h7FFF),
                    $urandom_range(0, 'hA000), $urandom_range(0, (r == 5) ? 'hFFFF : 'h2000));
            for (int i = 0; i < 250; i++) begin
                tick($urandom_range(0, 3) != 0, $urandom_range(0, 3), W'($urandom),
                     $urandom_range(0, 7) == 0, 1'b0);
            end
        end

        idle(10);
        check("drain_empty", exp_due_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
